// File: rtl/tlul_pkg.sv
// TL-UL channel types and opcode constants shared by the boot copier and its bench.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [13:0] a_user;
    logic        d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [13:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tlul_d2h_t;

  localparam logic [2:0]  Get              = 3'd4;
  localparam logic [2:0]  AccessAck        = 3'd0;
  localparam logic [2:0]  AccessAckData    = 3'd1;
  localparam logic [13:0] TlAUserDefault   = 14'h0;

endpackage

// File: rtl/rom_boot_copier.sv
// Boot ROM to SRAM copier: a TL-UL host that reads sequential ROM words with
// up to MAX_OUT Gets in flight and streams each good word into a destination
// SRAM write port, reporting done/error to the boot controller.
module rom_boot_copier
  import tlul_pkg::*;
#(
  parameter int          AW       = 8,
  parameter int          DW       = 32,
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter int          DST_AW   = 10,
  parameter int          MAX_OUT  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [AW:0]       len_i,
  input  logic [DST_AW-1:0] dst_base_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output tlul_h2d_t         tl_h_o,
  input  tlul_d2h_t         tl_h_i,
  output logic              dst_we_o,
  output logic [DST_AW-1:0] dst_addr_o,
  output logic [DW-1:0]     dst_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [AW:0] ONE = 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [AW:0]       r_len;
  logic [AW:0]       r_iss;
  logic [AW:0]       r_rsp;
  logic [1:0]        r_out;
  logic [DST_AW-1:0] r_base;
  logic              r_done;
  logic              r_err;
  logic              r_we;
  logic [DST_AW-1:0] r_addr;
  logic [DW-1:0]     r_wdata;

  logic              w_start_ok;
  logic              w_a_valid;
  logic              w_d_ready;
  logic              w_a_fire;
  logic              w_d_fire;
  logic              w_d_err;
  logic              w_last_rsp;
  logic [1:0]        w_out_nxt;
  logic              w_unused;

  // Handshake qualifiers; a_valid depends only on registered state so the
  // request stays stable until the ROM accepts it.
  always_comb begin
    w_start_ok = start_i && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    w_a_valid  = (r_state == S_RUN) && (r_iss < r_len) && (r_out < 2'(MAX_OUT));
    w_d_ready  = (r_state == S_RUN) || (r_state == S_DRAIN);
    w_a_fire   = w_a_valid && tl_h_i.a_ready;
    w_d_fire   = tl_h_i.d_valid && w_d_ready;
    w_d_err    = w_d_fire && tl_h_i.d_error;
    w_last_rsp = (r_rsp + ONE) == r_len;
    w_out_nxt  = r_out + 2'(w_a_fire) - 2'(w_d_fire);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: zero-length starts complete at once, an error response
  // drains the remaining reads before settling in ERR.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_start_ok) w_state_nxt = (len_i == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_d_err)                     w_state_nxt = S_DRAIN;
        else if (w_d_fire && w_last_rsp) w_state_nxt = S_DONE;
      end
      S_DRAIN: begin
        if (r_out == 2'd0) w_state_nxt = S_ERR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transfer counters, sticky status flags and the registered SRAM write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_len   <= '0;
      r_base  <= '0;
      r_iss   <= '0;
      r_rsp   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we   <= 1'b0;
      r_done <= (w_state_nxt == S_DONE) || (w_state_nxt == S_ERR);
      if (w_start_ok) begin
        r_len  <= len_i;
        r_base <= dst_base_i;
        r_iss  <= '0;
        r_rsp  <= '0;
        r_out  <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_a_fire) r_iss <= r_iss + ONE;
        if (w_d_fire) r_rsp <= r_rsp + ONE;
        r_out <= w_out_nxt;
        if (w_d_err) r_err <= 1'b1;
        if (w_d_fire && !tl_h_i.d_error && (r_state == S_RUN) &&
            (tl_h_i.d_opcode == AccessAckData)) begin
          r_we    <= 1'b1;
          r_addr  <= r_base + DST_AW'(r_rsp);
          r_wdata <= tl_h_i.d_data;
        end
      end
    end
  end

  // Request channel: fixed 32-bit Get, source tracks the low issue bit.
  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = w_a_valid;
    tl_h_o.a_opcode  = Get;
    tl_h_o.a_param   = 3'd0;
    tl_h_o.a_size    = 2'd2;
    tl_h_o.a_source  = 8'(r_iss[0]);
    tl_h_o.a_address = ROM_BASE + (32'(r_iss) << 2);
    tl_h_o.a_mask    = 4'hF;
    tl_h_o.a_data    = 32'h0;
    tl_h_o.a_user    = TlAUserDefault;
    tl_h_o.d_ready   = w_d_ready;
  end

  assign busy_o      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign dst_we_o    = r_we;
  assign dst_addr_o  = r_addr;
  assign dst_wdata_o = r_wdata;

  assign w_unused = ^{tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_source,
                      tl_h_i.d_sink, tl_h_i.d_user};

endmodule

// File: doc/rom_boot_copier.md
Name: rom_boot_copier

Overview:
- TL-UL host that sits directly upstream of the boot ROM's TL-UL device port.
- On a start pulse, it issues sequential 32-bit Get requests to the ROM and streams each returned word into a destination SRAM write port, such as the ICCM preload path.
- It flags completion or error to the boot controller.
- It keeps up to 2 reads outstanding, matching the ROM adapter's outstanding depth.

Parameters:
- AW, 8: ROM word-address width; the maximum transfer is 2^AW words.
- DW, 32: data width; fixed at 32 for TL-UL.
- ROM_BASE, 32'h0000_0000: byte base address of the ROM in the TL-UL map.
- DST_AW, 10: destination SRAM word-address width.
- MAX_OUT, 2: maximum outstanding Get requests (1 or 2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle start pulse; accepted only in IDLE, DONE or ERR
- len_i  in  AW+1  number of words to copy; sampled on accepted start
- dst_base_i  in  DST_AW  destination start word address; sampled on accepted start
- busy_o  out  1  high while in RUN or DRAIN
- done_o  out  1  sticky; set on completion (including error); cleared by the next accepted start
- err_o  out  1  sticky; set if any response has d_error=1
- tl_h_o  out  tlul_h2d_t  TL-UL request channel to the ROM
- tl_h_i  in  tlul_d2h_t  TL-UL response channel from the ROM
- dst_we_o  out  1  destination write strobe, 1 cycle per word
- dst_addr_o  out  DST_AW  destination word address
- dst_wdata_o  out  DW  destination write data

Behaviour:
- Reset: state=IDLE; busy_o, done_o, err_o, dst_we_o = 0; dst_addr_o, dst_wdata_o = 0; a_valid=0; d_ready=0; all counters 0.
- FSM states: IDLE, RUN, DRAIN, DONE, ERR.
- Accepted start: latches len_i and dst_base_i; clears done_o and err_o; zeroes the issue count (iss), response count (rsp) and outstanding count (out).
  - If len_i==0, go directly to DONE with done_o=1 on the next cycle and issue no TL traffic.
  - Otherwise go to RUN.
- Start while busy_o=1 is ignored.
- A request in RUN:
  - a_valid=1 when iss<len and out<MAX_OUT.
  - a_opcode=Get (4), a_param=0, a_size=2, a_mask=4'hF, a_data=0, a_source=iss[0], a_user=default.
  - a_address = ROM_BASE + (iss<<2), truncated to 32 bits.
- Handshake: the request fires when a_valid && a_ready; iss and out increment on that cycle.
  - Once a_valid is raised, it holds with stable fields until a_ready.
- d_ready=1 in RUN and DRAIN; 0 otherwise.
- Response fires when d_valid && d_ready. Responses are in order. Each fire decrements out and increments rsp.
  - If d_opcode==AccessAckData and d_error==0: dst_we_o=1 on the following cycle (registered), with dst_addr_o = dst_base + rsp (wraps modulo 2^DST_AW) and dst_wdata_o = d_data.
  - If d_error==1: set err_o, write nothing for that word, stop issuing, go to DRAIN.
- Same-cycle request fire and response fire: out stays unchanged; iss and rsp both increment.
- Completion: when rsp reaches len in RUN (last response fires), go to DONE. done_o=1 on the cycle after the last response, coincident with the last dst_we_o.
- DRAIN: no new requests. Stay until out==0, then go to ERR with done_o=1 and err_o=1. The FSM cannot leave DRAIN with reads still outstanding.
- DONE/ERR: busy_o=0; hold done_o and err_o until the next accepted start.
- Latency: first a_valid appears 1 cycle after start. With a ROM answering 1 cycle after the request, sustained throughput is 1 word per cycle at MAX_OUT=2.
- Reset mid-transfer: the FSM returns to IDLE immediately and drops a_valid and d_ready. Late ROM responses arriving after reset are not consumed.
- Maximum transfer: len_i = 2^AW. iss uses AW+1 bits, so no wrap occurs.

Test Plan:
- Reset, then start with len=4 and dst_base=0x10; ROM holds 0xA0..0xA3 at words 0..3 -> four Gets at addresses ROM_BASE+0,4,8,C; writes 0xA0..0xA3 to dst 0x10..0x13 in order; done_o=1, err_o=0, busy_o=0.
- len=0 -> no a_valid ever; done_o=1 one cycle after start; no dst_we_o.
- Throttle a_ready low for 3 cycles during word 2 -> a_address holds 0x8 with stable fields until accepted; never more than 2 outstanding; data still correct.
- d_error=1 on word 1 of len=8 -> word 0 written, word 1 not written; no requests after the error; remaining outstanding reads drained; ERR state with done_o=1 and err_o=1.
- dst_base=2^DST_AW-2 with len=4 -> dst_addr_o sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Assert rst_i mid-transfer, then start a new transfer with len=2 -> clean restart from word 0; done_o was cleared by reset and is set only by the new transfer; a second start pulse while busy is ignored.
